// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
// No logic, so no latency or backpressure of its own.
// Users: fetch_buffer, fetch_unit.
package riscv_pkg;

    localparam int XLEN = 32;

    // Canonical NOP: addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Generic in-order FIFO with push/pop/clear, occupancy count and head read.
// Latency: a push is visible at the head on the cycle after the push edge; there is no bypass.
// Backpressure: a push into a full buffer is accepted only together with a pop. Clear wins over push and pop.
module fetch_buffer #(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    occ
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_pop;
    logic             do_push;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign do_pop   = pop && (occ != '0);
    assign do_push  = push && ((occ != FULL) || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            occ <= occ + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset; occ guards every read that matters.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch PC owner: issues imem requests, buffers in-order responses, presents PC/instr to F->D.
// Latency: a response at edge N is presented with validF=1 after edge N (one buffer stage).
// Backpressure: outstanding + buffered fetches are capped at DEPTH, so responses are never refused.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stallD,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    output logic [DATA_WIDTH-1:0] PCounterF,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] PCPlus4F,
    output logic                  validF
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] fetch_pc;
    logic [DATA_WIDTH-1:0] tag_pc;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         stale_cnt;
    logic [CW-1:0]         occ;
    logic [CW:0]           in_use;
    logic                  accept;
    logic                  resp_keep;
    logic                  pop;
    fetch_entry_t          push_entry;
    fetch_entry_t          head;

    assign in_use         = {1'b0, outstanding} + {1'b0, occ};
    assign imem_req_valid = !rst && !redirect_valid && (in_use < CREDITS);
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;

    // A response is kept only if it is not owed to a flushed path, including one landing on the redirect cycle.
    assign resp_keep  = imem_resp_valid && (stale_cnt == '0) && !redirect_valid;
    assign push_entry = '{pc: tag_pc, instr: imem_resp_data};

    assign validF    = (occ != '0);
    assign pop       = !stallD && validF && !redirect_valid;
    assign PCounterF = validF ? head.pc : '0;
    assign instr     = validF ? head.instr : NOP_INSTR;
    assign PCPlus4F  = PCounterF + DATA_WIDTH'(4);

    // Tag queue occupancy doubles as the outstanding-request count; it survives redirects so stale responses still pop their tag.
    fetch_buffer #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_tag_q (
        .clk      (clk),
        .rst      (rst),
        .push     (accept),
        .push_dat (fetch_pc),
        .pop      (imem_resp_valid),
        .clear    (1'b0),
        .head_dat (tag_pc),
        .occ      (outstanding)
    );

    fetch_buffer #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_data_q (
        .clk      (clk),
        .rst      (rst),
        .push     (resp_keep),
        .push_dat (push_entry),
        .pop      (pop),
        .clear    (redirect_valid),
        .head_dat (head),
        .occ      (occ)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            stale_cnt <= '0;
        end else if (redirect_valid) begin
            fetch_pc  <= redirect_pc;
            stale_cnt <= outstanding - CW'(imem_resp_valid);
        end else begin
            if (accept) fetch_pc <= fetch_pc + DATA_WIDTH'(4);
            if (imem_resp_valid && (stale_cnt != '0)) stale_cnt <= stale_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (in_use <= CREDITS);
            assert (stale_cnt <= outstanding);
            assert (!imem_resp_valid || (outstanding != '0));
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed checks of fetch_unit against a queue-based reference model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallD, redirect_valid, imem_req_ready, imem_resp_valid;
    logic [31:0] redirect_pc, imem_resp_data;
    logic        imem_req_valid, validF;
    logic [31:0] imem_req_addr, PCounterF, instr, PCPlus4F;

    logic        w_stall, w_ready, w_resp_valid;
    logic [31:0] w_resp_data;
    logic        w_req_valid, w_validF;
    logic [31:0] w_addr, w_pc, w_instr, w_pc4;

    always #5 clk = ~clk;

    fetch_unit u_dut (
        .clk(clk), .rst(rst), .stallD(stallD),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .PCounterF(PCounterF),
        .instr(instr), .PCPlus4F(PCPlus4F), .validF(validF)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst), .stallD(w_stall),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_ready),
        .imem_req_addr(w_addr), .imem_resp_valid(w_resp_valid),
        .imem_resp_data(w_resp_data), .PCounterF(w_pc),
        .instr(w_instr), .PCPlus4F(w_pc4), .validF(w_validF)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: memory in-flight list, presented-instruction queue, expected PC streams.
    logic [31:0] mq_addr [$];
    bit          mq_stale[$];
    int          mq_due  [$];
    logic [31:0] bq      [$];
    logic [31:0] exp_req, exp_cons;

    int          p_ready, p_resp, p_stall, p_redir, max_lat;
    bit          f_redir, f_resp;
    logic [31:0] f_target;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at posedge+1, check and advance the model at negedge.
    task automatic step();
        bit          redir, exp_rv, acc, popf, keep;
        logic [31:0] tgt, raddr;
        imem_req_ready  = ($urandom_range(0, 99) < p_ready);
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc && (f_resp || $urandom_range(0, 99) < p_resp)) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mq_addr[0] | 32'h1;
        end
        stallD = ($urandom_range(0, 99) < p_stall);
        redir  = f_redir || ($urandom_range(0, 99) < p_redir);
        tgt    = f_redir ? f_target : 32'h2000 + ($urandom_range(0, 1023) << 2);
        redirect_valid = redir;
        redirect_pc    = tgt;
        f_redir = 1'b0;
        f_resp  = 1'b0;

        @(negedge clk);
        exp_rv = !redir && (mq_addr.size() + bq.size() < 2);
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        if (exp_rv) chk("req_addr", imem_req_addr, exp_req);
        chk("validF", {31'b0, validF}, {31'b0, bq.size() > 0});
        if (bq.size() > 0) begin
            chk("head_pc", PCounterF, bq[0]);
            chk("head_instr", instr, bq[0] | 32'h1);
            chk("head_pc4", PCPlus4F, bq[0] + 32'd4);
        end else begin
            chk("empty_pc", PCounterF, 32'h0);
            chk("empty_instr", instr, NOP);
            chk("empty_pc4", PCPlus4F, 32'h4);
        end
        popf = !stallD && (bq.size() > 0) && !redir;
        if (popf) begin
            chk("consume_order", PCounterF, exp_cons);
            exp_cons += 32'd4;
        end

        acc  = exp_rv && imem_req_ready;
        keep = 1'b0;
        raddr = '0;
        if (imem_resp_valid) begin
            keep  = !mq_stale[0] && !redir;
            raddr = mq_addr.pop_front();
            void'(mq_stale.pop_front());
            void'(mq_due.pop_front());
        end
        if (popf) void'(bq.pop_front());
        if (keep) bq.push_back(raddr);
        if (redir) begin
            bq.delete();
            foreach (mq_stale[i]) mq_stale[i] = 1'b1;
            exp_req  = tgt;
            exp_cons = tgt;
        end
        if (acc) begin
            mq_addr.push_back(exp_req);
            mq_stale.push_back(1'b0);
            mq_due.push_back(cyc + 1 + $urandom_range(0, max_lat));
            exp_req += 32'd4;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        logic [31:0] waddr[$];
        logic [31:0] wpc[$];
        logic [31:0] wpc4[$];
        bit          prev_acc;
        logic [31:0] prev_addr;

        rst = 1'b1;
        stallD = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        w_stall = 1'b1; w_ready = 1'b0; w_resp_valid = 1'b0; w_resp_data = '0;
        f_redir = 1'b0; f_resp = 1'b0; f_target = '0;
        exp_req = 32'h0; exp_cons = 32'h0;

        // Reset values
        @(negedge clk);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("rst_validF", {31'b0, validF}, 32'h0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc", PCounterF, 32'h0);
        chk("rst_pc4", PCPlus4F, 32'h4);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming with an always-ready, one-cycle memory
        p_ready = 100; p_resp = 100; max_lat = 0; p_stall = 0; p_redir = 0;
        step();
        chk("first_not_yet_valid", {31'b0, validF}, 32'h0);
        step();
        chk("first_validF", {31'b0, validF}, 32'h1);
        chk("first_pc", PCounterF, 32'h0);
        chk("first_instr", instr, 32'h1);
        chk("first_pc4", PCPlus4F, 32'h4);
        repeat (20) step();

        // Held stall, then release
        p_stall = 100;
        repeat (5) step();
        p_stall = 0;
        repeat (10) step();

        // Mixed random traffic
        p_ready = 70; p_resp = 70; max_lat = 3; p_stall = 30; p_redir = 5;
        repeat (1500) step();

        // Redirect with two live requests in flight
        p_redir = 0; p_stall = 0; p_ready = 100; p_resp = 100;
        repeat (10) step();
        p_resp = 0;
        for (int i = 0; i < 20 && !(mq_addr.size() == 2 && !mq_stale[0] && !mq_stale[1]); i++) step();
        chk("setup_two_inflight", {31'b0, mq_addr.size() == 2}, 32'h1);
        f_redir = 1'b1; f_target = 32'h100;
        step();
        chk("redirect_addr", imem_req_addr, 32'h100);
        p_resp = 100;
        repeat (10) step();

        // Redirect coinciding with a response and a would-be pop
        max_lat = 0;
        for (int i = 0; i < 20 && !(bq.size() > 0 && mq_addr.size() > 0 && !mq_stale[0]); i++) step();
        chk("setup_redirect_collide", {31'b0, bq.size() > 0 && mq_addr.size() > 0}, 32'h1);
        f_redir = 1'b1; f_resp = 1'b1; f_target = 32'h300;
        step();
        chk("collide_flushed", {31'b0, validF}, 32'h0);
        repeat (10) step();

        // Async reset with the buffer full
        p_stall = 100;
        for (int i = 0; i < 20 && bq.size() != 2; i++) step();
        chk("setup_full", {31'b0, validF && bq.size() == 2}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("async_validF", {31'b0, validF}, 32'h0);
        chk("async_instr", instr, NOP);
        chk("async_pc", PCounterF, 32'h0);
        chk("async_pc4", PCPlus4F, 32'h4);
        mq_addr.delete(); mq_stale.delete(); mq_due.delete(); bq.delete();
        exp_req = 32'h0; exp_cons = 32'h0;
        imem_resp_valid = 1'b0; redirect_valid = 1'b0; stallD = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        p_stall = 0; p_ready = 100; p_resp = 100;
        repeat (20) step();

        // Address wrap on the second instance; the main instance is parked
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; stallD = 1'b1; redirect_valid = 1'b0;
        w_stall = 1'b0; w_ready = 1'b1;
        prev_acc = 1'b0; prev_addr = '0;
        for (int i = 0; i < 12; i++) begin
            w_resp_valid = prev_acc;
            w_resp_data  = prev_addr | 32'h1;
            @(negedge clk);
            if (w_validF) begin
                wpc.push_back(w_pc);
                wpc4.push_back(w_pc4);
            end
            if (w_req_valid) waddr.push_back(w_addr);
            prev_acc  = w_req_valid;
            prev_addr = w_addr;
            @(posedge clk);
            #1;
        end
        w_resp_valid = 1'b0; w_ready = 1'b0; w_stall = 1'b1;
        chk("wrap_req_count", {31'b0, waddr.size() >= 3}, 32'h1);
        chk("wrap_pres_count", {31'b0, wpc.size() >= 3}, 32'h1);
        if (waddr.size() >= 3) begin
            chk("wrap_addr0", waddr[0], 32'hFFFF_FFF8);
            chk("wrap_addr1", waddr[1], 32'hFFFF_FFFC);
            chk("wrap_addr2", waddr[2], 32'h0);
        end
        if (wpc.size() >= 3) begin
            chk("wrap_pc1", wpc[1], 32'hFFFF_FFFC);
            chk("wrap_pc4_1", wpc4[1], 32'h0);
            chk("wrap_pc2", wpc[2], 32'h0);
        end

        // More random traffic on the main instance
        p_ready = 80; p_resp = 60; max_lat = 2; p_stall = 25; p_redir = 4;
        repeat (500) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
